i2s_mic_array_rx: RTL and testbench

Upstream capture stage for the beamforming datapath. Acts as I2S bus master for four I2S MEMS microphones wired as two stereo pairs on two data lines, and deserialises one 24-bit two's-complement sample per mic per frame. Presents all four samples simultaneously with a single-cycle valid strobe, in the form the delay-and-sum stage takes as its audio_in_1..4 and valid_in.

---
 rtl/i2s_mic_array_rx.sv | 120 ++++++++++++
 tb/tb_i2s_mic_array_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_array_rx.sv
// i2s_mic_array_rx: I2S master for two stereo MEMS mic pairs, emits four samples per frame with one valid strobe
module i2s_mic_array_rx #(
    parameter int BITS_AUDIO     = 24,
    parameter int CLK_DIV_HALF   = 16,
    parameter int DISCARD_FRAMES = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    output logic                         sck_out,
    output logic                         ws_out,
    input  logic                         sd_a_in,
    input  logic                         sd_b_in,
    output logic signed [BITS_AUDIO-1:0] audio_out_1,
    output logic signed [BITS_AUDIO-1:0] audio_out_2,
    output logic signed [BITS_AUDIO-1:0] audio_out_3,
    output logic signed [BITS_AUDIO-1:0] audio_out_4,
    output logic                         valid_out
);
    localparam int DW = $clog2(CLK_DIV_HALF);

    logic [DW-1:0]         div;
    logic [5:0]            bit_cnt;
    logic [5:0]            bit_nxt;
    logic [7:0]            disc;
    logic [1:0]            sync_a;
    logic [1:0]            sync_b;
    logic [BITS_AUDIO-1:0] sr_1;
    logic [BITS_AUDIO-1:0] sr_2;
    logic [BITS_AUDIO-1:0] sr_3;
    logic [BITS_AUDIO-1:0] sr_4;
    logic                  done;
    logic                  wrap;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  in_left;
    logic                  in_right;

    // Edge strobes and capture windows; data sits one bit after each WS change
    always_comb begin
        wrap     = div == DW'(CLK_DIV_HALF - 1);
        rise_stb = wrap && !sck_out;
        fall_stb = wrap && sck_out;
        bit_nxt  = bit_cnt + 6'd1;
        in_left  = bit_cnt >= 6'd1 && bit_cnt <= 6'(BITS_AUDIO);
        in_right = bit_cnt >= 6'd33 && bit_cnt <= 6'(32 + BITS_AUDIO);
    end

    // Bit clock divider, 64-bit frame counter and WS, all changing on the SCK falling edge
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            div     <= '0;
            sck_out <= 1'b0;
            bit_cnt <= '0;
            ws_out  <= 1'b0;
        end else begin
            div <= wrap ? '0 : div + DW'(1);
            if (wrap) sck_out <= ~sck_out;
            if (fall_stb) begin
                bit_cnt <= bit_nxt;
                ws_out  <= bit_nxt[5];
            end
        end
    end

    // Two-flop synchronisers for the asynchronous mic data lines
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], sd_a_in};
            sync_b <= {sync_b[0], sd_b_in};
        end
    end

    // MSB-first deserialisers, one per mic, shifting on SCK rise inside their slot window
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sr_1 <= '0;
            sr_2 <= '0;
            sr_3 <= '0;
            sr_4 <= '0;
        end else if (rise_stb) begin
            if (in_left) begin
                sr_1 <= (sr_1 << 1) | BITS_AUDIO'(sync_a[1]);
                sr_3 <= (sr_3 << 1) | BITS_AUDIO'(sync_b[1]);
            end
            if (in_right) begin
                sr_2 <= (sr_2 << 1) | BITS_AUDIO'(sync_a[1]);
                sr_4 <= (sr_4 << 1) | BITS_AUDIO'(sync_b[1]);
            end
        end
    end

    // Frame completion: drop start-up frames, then publish all four samples with a one-cycle strobe
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            done        <= 1'b0;
            disc        <= '0;
            valid_out   <= 1'b0;
            audio_out_1 <= '0;
            audio_out_2 <= '0;
            audio_out_3 <= '0;
            audio_out_4 <= '0;
        end else begin
            done      <= rise_stb && bit_cnt == 6'(32 + BITS_AUDIO);
            valid_out <= done && disc == 8'(DISCARD_FRAMES);
            if (done) begin
                if (disc == 8'(DISCARD_FRAMES)) begin
                    audio_out_1 <= sr_1;
                    audio_out_2 <= sr_2;
                    audio_out_3 <= sr_3;
                    audio_out_4 <= sr_4;
                end else begin
                    disc <= disc + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// tb_i2s_mic_array_rx: mic-model bench for the default and the fast/no-discard configuration
module tb_i2s_mic_array_rx;
    localparam int B = 24;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                rst   [2];
    logic                sck   [2];
    logic                ws    [2];
    logic                sd_a  [2];
    logic                sd_b  [2];
    logic                vld   [2];
    logic signed [B-1:0] aud   [2][4];

    i2s_mic_array_rx #(.BITS_AUDIO(B), .CLK_DIV_HALF(16), .DISCARD_FRAMES(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst[0]), .sck_out(sck[0]), .ws_out(ws[0]),
        .sd_a_in(sd_a[0]), .sd_b_in(sd_b[0]),
        .audio_out_1(aud[0][0]), .audio_out_2(aud[0][1]), .audio_out_3(aud[0][2]), .audio_out_4(aud[0][3]),
        .valid_out(vld[0])
    );

    i2s_mic_array_rx #(.BITS_AUDIO(B), .CLK_DIV_HALF(4), .DISCARD_FRAMES(0)) u_fast (
        .clk_in(clk_in), .rst_in(rst[1]), .sck_out(sck[1]), .ws_out(ws[1]),
        .sd_a_in(sd_a[1]), .sd_b_in(sd_b[1]),
        .audio_out_1(aud[1][0]), .audio_out_2(aud[1][1]), .audio_out_3(aud[1][2]), .audio_out_4(aud[1][3]),
        .valid_out(vld[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int half(input int i);
        return i == 0 ? 16 : 4;
    endfunction

    function automatic int ndisc(input int i);
        return i == 0 ? 2 : 0;
    endfunction

    // Mic model state: words of the frame in flight, and the scoreboard of frames that must appear
    int             pos      [2];
    int             frm      [2];
    int             mode     [2];
    logic           prev_sck [2];
    logic           prev_ws  [2];
    logic [B-1:0]   w        [2][4];
    logic           junk     [2];
    logic [B-1:0]   next_w   [2][4];
    logic           next_junk[2];
    logic [4*B-1:0] exp_q    [2][$];

    task automatic pick(input int i);
        for (int m = 0; m < 4; m++)
            w[i][m] = mode[i] == 0 ? next_w[i][m] :
                      mode[i] == 1 ? B'(frm[i] + m * 32'h100000) : B'($urandom);
        junk[i] = mode[i] == 0 ? next_junk[i] : 1'($urandom);
    endtask

    // Mics: count SCK falls since the last WS edge; bit k of a slot goes out at position k+1
    always @(negedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                pos[i] = 0;
                frm[i] = 1;
                prev_ws[i] = 1'b0;
                exp_q[i].delete();
                pick(i);
            end else if (prev_sck[i] && !sck[i]) begin
                if (ws[i] != prev_ws[i]) begin
                    pos[i] = 0;
                    if (!ws[i]) begin
                        frm[i]++;
                        pick(i);
                    end
                end else begin
                    pos[i]++;
                end
                prev_ws[i] = ws[i];
                if (ws[i] && pos[i] == B && frm[i] > ndisc(i))
                    exp_q[i].push_back({w[i][0], w[i][1], w[i][2], w[i][3]});
            end
            prev_sck[i] = sck[i];
            if (pos[i] >= 1 && pos[i] <= B) begin
                sd_a[i] = w[i][prev_ws[i] ? 1 : 0][B - pos[i]];
                sd_b[i] = w[i][prev_ws[i] ? 3 : 2][B - pos[i]];
            end else begin
                sd_a[i] = junk[i];
                sd_b[i] = junk[i];
            end
        end
    end

    // Protocol monitor and scoreboard: clock periods, WS timing, single-cycle valid, frame data
    logic ps1 [2];
    logic ps2 [2];
    logic pws [2];
    logic pv  [2];
    int   last_r [2];
    int   last_w [2];
    int   last_v [2];
    always @(negedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                last_r[i] = -1;
                last_w[i] = -1;
                last_v[i] = -1;
            end else begin
                if (sck[i] && !ps1[i]) begin
                    if (last_r[i] >= 0) chk($sformatf("sck_period%0d", i), cyc - last_r[i], 2 * half(i));
                    last_r[i] = cyc;
                end
                if (ws[i] != pws[i]) begin
                    chk($sformatf("ws_on_sck_fall%0d", i), !sck[i] && (ps1[i] || ps2[i]), 1);
                    if (ws[i]) begin
                        if (last_w[i] >= 0) chk($sformatf("ws_period%0d", i), cyc - last_w[i], 128 * half(i));
                        last_w[i] = cyc;
                    end
                end
                if (vld[i]) begin
                    chk($sformatf("valid_one_cycle%0d", i), pv[i], 0);
                    if (last_v[i] >= 0) chk($sformatf("valid_period%0d", i), cyc - last_v[i], 128 * half(i));
                    last_v[i] = cyc;
                    chk($sformatf("pending_frames%0d", i), exp_q[i].size(), 1);
                    if (exp_q[i].size() > 0) begin
                        logic [4*B-1:0] e;
                        e = exp_q[i].pop_front();
                        for (int m = 0; m < 4; m++)
                            chk($sformatf("sb%0d_mic%0d", i, m + 1), $unsigned(aud[i][m]), e[(4-m)*B-1 -: B]);
                    end
                end
            end
            ps2[i] = ps1[i];
            ps1[i] = sck[i];
            pws[i] = ws[i];
            pv[i]  = vld[i];
        end
    end

    task automatic wait_valid(input int i, input int budget, output bit got);
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk_in);
            got = vld[i];
        end
        chk($sformatf("valid_arrives%0d", i), got, 1);
    endtask

    typedef struct {
        logic [4*B-1:0] din;
        logic           junk;
        logic [4*B-1:0] dexp;
    } vec_t;
    vec_t tbl [4];

    task automatic set_row(input int r);
        for (int m = 0; m < 4; m++) next_w[0][m] = tbl[r].din[(4-m)*B-1 -: B];
        next_junk[0] = tbl[r].junk;
    endtask

    bit fast_done = 1'b0;

    // Fast instance: no discard, so the very first frame must be published
    initial begin
        bit got;
        int t1;
        wait (rst[1] === 1'b1);
        t1 = cyc;
        wait_valid(1, 1024, got);
        chk("fast_first_valid_frame1", (cyc - t1) > 0 && (cyc - t1) < 512, 1);
        repeat (20) wait_valid(1, 1024, got);
        fast_done = 1'b1;
    end

    initial begin
        repeat (95000) @(posedge clk_in);
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        bit got;
        int t_rel;
        tbl[0] = '{{24'h123456, 24'hABCDEF, 24'h000001, 24'h800000}, 1'b0,
                   {24'h123456, 24'hABCDEF, 24'h000001, 24'h800000}};
        tbl[1] = '{{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 1'b1,
                   {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}};
        tbl[2] = '{{24'h000000, 24'h000000, 24'h000000, 24'h000000}, 1'b1,
                   {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
        tbl[3] = '{{24'h800000, 24'h7FFFFF, 24'h5A5A5A, 24'h000000}, 1'b1,
                   {24'h800000, 24'h7FFFFF, 24'h5A5A5A, 24'h000000}};
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        mode[0] = 0;
        mode[1] = 2;
        set_row(0);
        next_junk[1] = 1'b0;
        for (int m = 0; m < 4; m++) next_w[1][m] = '0;
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_sck%0d", i), sck[i], 0);
            chk($sformatf("rst_ws%0d", i), ws[i], 0);
            chk($sformatf("rst_valid%0d", i), vld[i], 0);
            for (int m = 0; m < 4; m++) chk($sformatf("rst_aud%0d_%0d", i, m + 1), $unsigned(aud[i][m]), 0);
        end
        @(posedge clk_in);
        #2;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        t_rel = cyc;
        for (int r = 0; r < 4; r++) begin
            wait_valid(0, 4 * 2048, got);
            if (r == 0) begin
                chk("first_valid_in_frame3", (cyc - t_rel) > 2 * 2048 && (cyc - t_rel) < 3 * 2048, 1);
                chk("mic2_negative", $signed(aud[0][1]) < 0, 1);
            end
            for (int m = 0; m < 4; m++)
                chk($sformatf("row%0d_mic%0d", r, m + 1), $unsigned(aud[0][m]), tbl[r].dexp[(4-m)*B-1 -: B]);
            if (r < 3) set_row(r + 1);
        end
        mode[0] = 1;
        repeat (4) wait_valid(0, 2 * 2048, got);
        mode[0] = 2;
        repeat (4) wait_valid(0, 2 * 2048, got);
        got = 1'b0;
        for (int n = 0; n < 4096 && !got; n++) begin
            @(negedge clk_in);
            got = ws[0] && pos[0] == 8;
        end
        chk("found_bit40", got, 1);
        rst[0] = 1'b0;
        repeat (3) @(posedge clk_in);
        #2;
        rst[0] = 1'b1;
        t_rel = cyc;
        wait_valid(0, 4 * 2048, got);
        chk("post_reset_valid_in_frame3", (cyc - t_rel) > 2 * 2048 && (cyc - t_rel) < 3 * 2048, 1);
        wait_valid(0, 2 * 2048, got);
        wait (fast_done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
